// File: rtl/secuenciador_carga.sv
// Steps an operand/opcode/execute/show load sequence from a debounced "next" button.
// Strobe is registered: it appears DEB_CYCLES+3 edges after a clean press; clr forces CARGA_A.
module secuenciador_carga #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       clr,
  output logic       enA,
  output logic       enB,
  output logic       enO,
  output logic       enS,
  output logic [2:0] paso
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  localparam logic [2:0] CARGA_A = 3'd0;
  localparam logic [2:0] CARGA_B = 3'd1;
  localparam logic [2:0] CARGA_O = 3'd2;
  localparam logic [2:0] EJEC    = 3'd3;
  localparam logic [2:0] MUESTRA = 3'd4;

  logic          btn_s1_q, btn_s2_q;
  logic          clr_s1_q, clr_s2_q;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic          btn_deb_q, btn_deb_d;
  logic          btn_deb_prev_q;
  logic          press;
  logic [2:0]    state_q, state_d;
  logic          en_a_q, en_a_d;
  logic          en_b_q, en_b_d;
  logic          en_o_q, en_o_d;
  logic          en_s_q, en_s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      clr_s1_q <= 1'b0;
      clr_s2_q <= 1'b0;
    end else begin
      btn_s1_q <= btn;
      btn_s2_q <= btn_s1_q;
      clr_s1_q <= clr;
      clr_s2_q <= clr_s1_q;
    end
  end

  // Count consecutive disagreeing edges; the level flips on the DEB_CYCLES-th one.
  always_comb begin
    deb_cnt_d = '0;
    btn_deb_d = btn_deb_q;
    if (btn_s2_q != btn_deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_deb_d = btn_s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_q      <= '0;
      btn_deb_q      <= 1'b0;
      btn_deb_prev_q <= 1'b0;
    end else begin
      deb_cnt_q      <= deb_cnt_d;
      btn_deb_q      <= btn_deb_d;
      btn_deb_prev_q <= btn_deb_q;
    end
  end

  assign press = btn_deb_q & ~btn_deb_prev_q;

  always_comb begin
    state_d = state_q;
    en_a_d  = 1'b0;
    en_b_d  = 1'b0;
    en_o_d  = 1'b0;
    en_s_d  = 1'b0;
    if (clr_s2_q) begin
      state_d = CARGA_A;
    end else begin
      case (state_q)
        CARGA_A: begin
          if (press) begin
            en_a_d  = 1'b1;
            state_d = CARGA_B;
          end
        end
        CARGA_B: begin
          if (press) begin
            en_b_d  = 1'b1;
            state_d = CARGA_O;
          end
        end
        CARGA_O: begin
          if (press) begin
            en_o_d  = 1'b1;
            state_d = EJEC;
          end
        end
        // One-cycle execute slot; a press landing here is dropped.
        EJEC: begin
          en_s_d  = 1'b1;
          state_d = MUESTRA;
        end
        MUESTRA: begin
          if (press) begin
            state_d = CARGA_A;
          end
        end
        default: begin
          state_d = CARGA_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CARGA_A;
      en_a_q  <= 1'b0;
      en_b_q  <= 1'b0;
      en_o_q  <= 1'b0;
      en_s_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_a_q  <= en_a_d;
      en_b_q  <= en_b_d;
      en_o_q  <= en_o_d;
      en_s_q  <= en_s_d;
    end
  end

  assign enA  = en_a_q;
  assign enB  = en_b_q;
  assign enO  = en_o_q;
  assign enS  = en_s_q;
  assign paso = state_q;

endmodule

// File: tb/tb_secuenciador_carga.sv
// Randomized and directed bench for secuenciador_carga against a step-counter reference model.
module tb_secuenciador_carga;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       clr;
  logic       enA, enB, enO, enS;
  logic [2:0] paso;

  always #5 clk = ~clk;

  secuenciador_carga #(.DEB_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .btn (btn),
    .clr (clr),
    .enA (enA),
    .enB (enB),
    .enO (enO),
    .enS (enS),
    .paso(paso)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: sync as a 2-deep delay line, debounce as a run length,
  // sequencer as a step index 0..4 where step 3 advances on its own.
  bit m_bpipe[2];
  bit m_cpipe[2];
  bit m_deb, m_prev;
  int m_run, m_step, m_en;

  task automatic model_reset();
    m_bpipe = '{0, 0};
    m_cpipe = '{0, 0};
    m_deb   = 0;
    m_prev  = 0;
    m_run   = 0;
    m_step  = 0;
    m_en    = 0;
  endtask

  task automatic model_step(input bit b, input bit c);
    bit pr;
    bit bs;
    bit cs;
    pr = m_deb && !m_prev;
    bs = m_bpipe[1];
    cs = m_cpipe[1];
    m_en = 0;
    if (cs) begin
      m_step = 0;
    end else if (m_step == 3 || pr) begin
      if (m_step < 4) m_en = 1 << m_step;
      m_step = (m_step + 1) % 5;
    end
    m_prev = m_deb;
    if (bs != m_deb) begin
      m_run++;
      if (m_run == D) begin
        m_deb = bs;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_bpipe[1] = m_bpipe[0];
    m_bpipe[0] = b;
    m_cpipe[1] = m_cpipe[0];
    m_cpipe[0] = c;
  endtask

  int edge_n = 0;
  int n_en[4] = '{0, 0, 0, 0};
  bit prev_eno = 0;

  function automatic int strobes();
    return int'({enS, enO, enB, enA});
  endfunction

  // Drive after a falling edge, advance model on the rising edge, compare on the next falling edge.
  task automatic tick(input bit b, input bit c);
    btn = b;
    clr = c;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(b, c);
    edge_n++;
    @(negedge clk);
    check_eq("paso", int'(paso), m_step);
    check_eq("strobe", strobes(), m_en);
    if (enA) n_en[0]++;
    if (enB) n_en[1]++;
    if (enO) n_en[2]++;
    if (enS) begin
      n_en[3]++;
      check_eq("ens_after_eno", int'(prev_eno), 1);
    end
    prev_eno = enO;
  endtask

  task automatic press_release();
    for (int i = 0; i < 10; i++) tick(1, 0);
    for (int i = 0; i < 10; i++) tick(0, 0);
  endtask

  task automatic measure_ena(input string tag);
    int base, first, width;
    base  = edge_n;
    first = -1;
    width = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1, 0);
      if (enA) begin
        if (first < 0) first = edge_n - base;
        width++;
      end
    end
    check_eq({tag, "_latency"}, first, D + 3);
    check_eq({tag, "_width"}, width, 1);
    check_eq({tag, "_paso"}, int'(paso), 1);
  endtask

  initial begin
    int s0, s1, s2, s3, found, hold;
    bit rb, rc;
    rst = 1'b1;
    btn = 1'b0;
    clr = 1'b0;
    model_reset();
    #12;
    check_eq("reset_paso", int'(paso), 0);
    check_eq("reset_strobe", strobes(), 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean press from CARGA_A.
    measure_ena("clean");
    for (int i = 0; i < 10; i++) tick(0, 0);

    // Remaining presses of the full sequence.
    s0 = n_en[0]; s1 = n_en[1]; s2 = n_en[2]; s3 = n_en[3];
    press_release();
    check_eq("seq_paso2", int'(paso), 2);
    press_release();
    check_eq("seq_paso4", int'(paso), 4);
    check_eq("seq_enb", n_en[1] - s1, 1);
    check_eq("seq_eno", n_en[2] - s2, 1);
    check_eq("seq_ens", n_en[3] - s3, 1);
    s0 = n_en[0] + n_en[1] + n_en[2] + n_en[3];
    press_release();
    check_eq("seq_paso_wrap", int'(paso), 0);
    check_eq("seq_no_strobe_4th", n_en[0] + n_en[1] + n_en[2] + n_en[3] - s0, 0);

    // Bounce then settle high: one enA only.
    s0 = n_en[0];
    for (int i = 0; i < 12; i++) tick(((i / 2) % 2) == 0, 0);
    for (int i = 0; i < 12; i++) tick(1, 0);
    for (int i = 0; i < 10; i++) tick(0, 0);
    check_eq("bounce_ena", n_en[0] - s0, 1);
    check_eq("bounce_paso", int'(paso), 1);

    // Short glitch: nothing happens.
    s0 = n_en[0] + n_en[1] + n_en[2] + n_en[3];
    for (int i = 0; i < 3; i++) tick(1, 0);
    for (int i = 0; i < 10; i++) tick(0, 0);
    check_eq("glitch_strobes", n_en[0] + n_en[1] + n_en[2] + n_en[3] - s0, 0);
    check_eq("glitch_paso", int'(paso), 1);

    // Clear overlapping the press in CARGA_O.
    press_release();
    check_eq("clr_pre_paso", int'(paso), 2);
    s2 = n_en[2];
    for (int t = 1; t <= 20; t++) begin
      tick(1, (t >= 5 && t <= 7));
      if (t == 7) check_eq("clr_paso_at_press", int'(paso), 0);
    end
    for (int i = 0; i < 10; i++) tick(0, 0);
    check_eq("clr_no_eno", n_en[2] - s2, 0);
    check_eq("clr_paso", int'(paso), 0);

    // Asynchronous reset in CARGA_B with btn held through release.
    press_release();
    check_eq("rst_pre_paso", int'(paso), 1);
    btn = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_paso", int'(paso), 0);
    check_eq("rst_async_strobe", strobes(), 0);
    model_reset();
    tick(1, 0);
    tick(1, 0);
    rst = 1'b0;
    measure_ena("rst_release");
    for (int i = 0; i < 10; i++) tick(0, 0);

    // Reset asserted while enB is high.
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1, 0);
      if (enB) found = 1;
    end
    check_eq("midstrobe_seen", found, 1);
    #1 rst = 1'b1;
    #1;
    check_eq("midstrobe_enb", int'(enB), 0);
    check_eq("midstrobe_paso", int'(paso), 0);
    model_reset();
    tick(0, 0);
    tick(0, 0);
    rst = 1'b0;

    // Random held levels with occasional clears.
    for (int n = 0; n < 300; n++) begin
      rb   = 1'($urandom_range(0, 1));
      rc   = ($urandom_range(0, 19) == 0);
      hold = $urandom_range(1, 10);
      for (int k = 0; k < hold; k++) tick(rb, rc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
